ibex_fetch_req_ctrl: RTL and testbench

- Request-side controller of the instruction prefetch path.
- Issues word-aligned requests on the instruction bus (req/gnt/rvalid) and tracks up to NUM_REQS outstanding requests.
- Drops responses made stale by a branch and pushes valid responses into the fetch FIFO's input port.
- On a branch it drives the FIFO clear together with the branch address.

---
 rtl/ibex_fetch_req_ctrl.sv | 133 +++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// rtl/ibex_fetch_req_ctrl.sv - request-side controller of the instruction prefetch path
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        fifo_ready_i,
  output logic        fifo_clear_o,
  output logic [31:0] fifo_addr_o,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_addr_q;
  logic [31:0]   req_addr_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] discard_q;
  logic          stale_q;

  logic [31:0]   branch_addr;
  logic          room;
  logic          gnt_taken;
  logic          wait_gnt;
  logic          rsp_drop;
  logic [CW-1:0] outstanding_d;
  logic [CW-1:0] discard_d;

  assign branch_addr = {addr_i[31:2], 2'b00};
  assign room        = outstanding_q < CW'(NUM_REQS);

  // A request parked in WAIT_GNT must stay on the bus unchanged until granted.
  always_comb begin
    instr_req_o  = 1'b0;
    instr_addr_o = fetch_addr_q;
    if (state_q == WAIT_GNT) begin
      instr_req_o  = rst_ni;
      instr_addr_o = req_addr_q;
    end else begin
      instr_req_o  = rst_ni & req_i & fifo_ready_i & room;
      instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
    end
  end

  assign gnt_taken = instr_req_o & instr_gnt_i;
  assign wait_gnt  = (state_q == WAIT_GNT) & instr_gnt_i;
  assign rsp_drop  = instr_rvalid_i & (discard_q != '0);

  assign outstanding_d = outstanding_q + CW'(gnt_taken) - CW'(instr_rvalid_i);

  // On a branch everything still in flight becomes stale, including an old-target grant this cycle.
  always_comb begin
    discard_d = discard_q;
    if (branch_i) begin
      discard_d = outstanding_q - CW'(instr_rvalid_i) + CW'(wait_gnt);
    end else begin
      discard_d = discard_q - CW'(rsp_drop) + CW'(wait_gnt & stale_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      fetch_addr_q  <= '0;
      req_addr_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      stale_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      case (state_q)
        IDLE: begin
          if (instr_req_o) begin
            fetch_addr_q <= instr_addr_o + 32'd4;
            if (!instr_gnt_i) begin
              req_addr_q <= instr_addr_o;
              state_q    <= WAIT_GNT;
            end
          end else if (branch_i) begin
            fetch_addr_q <= branch_addr;
          end
        end
        WAIT_GNT: begin
          if (branch_i) begin
            fetch_addr_q <= branch_addr;
          end
          if (instr_gnt_i) begin
            stale_q <= 1'b0;
            state_q <= IDLE;
          end else if (branch_i) begin
            stale_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_clear_o = rst_ni & branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_valid_o = rst_ni & instr_rvalid_i & (discard_q == '0) & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o | (outstanding_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      gnt_needs_req: assert (!instr_gnt_i || instr_req_o);
      rvalid_needs_outstanding: assert (!instr_rvalid_i || (outstanding_q != '0));
      discard_bounded: assert (discard_q <= outstanding_q);
    end
  end

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// tb/tb_ibex_fetch_req_ctrl.sv - directed self-checking bench for ibex_fetch_req_ctrl
module tb_ibex_fetch_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        fifo_ready_i = 1'b0;
  logic        fifo_clear_o;
  logic [31:0] fifo_addr_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_err_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock, then apply this cycle's inputs; checks follow after a settle delay.
  task automatic drive(input logic r, input logic b, input logic [31:0] a, input logic rdy,
                       input logic g, input logic rv, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    req_i          = r;
    branch_i       = b;
    addr_i         = a;
    fifo_ready_i   = rdy;
    instr_gnt_i    = g;
    instr_rvalid_i = rv;
    instr_rdata_i  = d;
    #1;
  endtask

  initial begin
    // reset with active inputs: request, valid and clear must all stay low
    rst_ni = 1'b0;
    drive(1, 1, 32'h82, 1, 0, 1, 32'hdead_beef);
    drive(1, 1, 32'h82, 1, 0, 1, 32'hdead_beef);
    check_eq("rst_req", instr_req_o, 0);
    check_eq("rst_valid", fifo_valid_o, 0);
    check_eq("rst_clear", fifo_clear_o, 0);
    check_eq("rst_busy", busy_o, 0);

    // 1: branch to 0x82, sequential fetch with immediate grants
    drive(1, 1, 32'h82, 1, 1, 0, 0);
    rst_ni = 1'b1;
    #1;
    check_eq("t1_clear", fifo_clear_o, 1);
    check_eq("t1_faddr", fifo_addr_o, 32'h82);
    check_eq("t1_req0", instr_req_o, 1);
    check_eq("t1_addr0", instr_addr_o, 32'h80);
    drive(1, 0, 0, 1, 1, 1, 32'ha000_0080);
    check_eq("t1_addr1", instr_addr_o, 32'h84);
    check_eq("t1_val1", fifo_valid_o, 1);
    check_eq("t1_data1", fifo_rdata_o, 32'ha000_0080);
    drive(1, 0, 0, 1, 1, 1, 32'ha000_0084);
    check_eq("t1_addr2", instr_addr_o, 32'h88);
    check_eq("t1_data2", fifo_rdata_o, 32'ha000_0084);
    drive(0, 0, 0, 1, 0, 1, 32'ha000_0088);
    check_eq("t1_req3", instr_req_o, 0);
    check_eq("t1_val3", fifo_valid_o, 1);
    check_eq("t1_data3", fifo_rdata_o, 32'ha000_0088);
    drive(0, 0, 0, 1, 0, 0, 0);
    check_eq("t1_idle_busy", busy_o, 0);

    // 2: held request without grant, then outstanding limit
    drive(1, 1, 32'h80, 1, 0, 0, 0);
    check_eq("t2_addr0", instr_addr_o, 32'h80);
    drive(0, 0, 0, 0, 0, 0, 0);
    check_eq("t2_hold_req", instr_req_o, 1);
    check_eq("t2_hold_addr", instr_addr_o, 32'h80);
    drive(1, 0, 0, 1, 1, 0, 0);
    check_eq("t2_gnt_addr", instr_addr_o, 32'h80);
    drive(1, 0, 0, 1, 1, 0, 0);
    check_eq("t2_addr1", instr_addr_o, 32'h84);
    drive(1, 0, 0, 1, 0, 0, 0);
    check_eq("t2_full_req", instr_req_o, 0);
    check_eq("t2_full_busy", busy_o, 1);
    drive(1, 0, 0, 1, 0, 1, 32'hd000_0080);
    check_eq("t2_full_req2", instr_req_o, 0);
    check_eq("t2_val", fifo_valid_o, 1);
    drive(1, 0, 0, 1, 1, 0, 0);
    check_eq("t2_reen_req", instr_req_o, 1);
    check_eq("t2_reen_addr", instr_addr_o, 32'h88);
    drive(0, 0, 0, 1, 0, 1, 32'hd000_0084);
    drive(0, 0, 0, 1, 0, 1, 32'hd000_0088);
    drive(0, 0, 0, 1, 0, 0, 0);
    check_eq("t2_drain_busy", busy_o, 0);

    // 3: branch with two outstanding drops both responses
    drive(1, 1, 32'h100, 1, 1, 0, 0);
    check_eq("t3_addr0", instr_addr_o, 32'h100);
    drive(1, 0, 0, 1, 1, 0, 0);
    check_eq("t3_addr1", instr_addr_o, 32'h104);
    drive(1, 1, 32'h200, 1, 0, 0, 0);
    check_eq("t3_br_req", instr_req_o, 0);
    check_eq("t3_br_clear", fifo_clear_o, 1);
    drive(1, 0, 0, 1, 0, 1, 32'h1111_1100);
    check_eq("t3_drop0", fifo_valid_o, 0);
    drive(1, 0, 0, 1, 1, 1, 32'h1111_1104);
    check_eq("t3_drop1", fifo_valid_o, 0);
    check_eq("t3_new_addr", instr_addr_o, 32'h200);
    drive(0, 0, 0, 1, 0, 1, 32'h2222_2200);
    check_eq("t3_new_val", fifo_valid_o, 1);
    check_eq("t3_new_data", fifo_rdata_o, 32'h2222_2200);

    // 4: branch while waiting for grant
    drive(1, 1, 32'h300, 1, 0, 0, 0);
    check_eq("t4_addr0", instr_addr_o, 32'h300);
    drive(1, 1, 32'h400, 1, 0, 0, 0);
    check_eq("t4_br_addr", instr_addr_o, 32'h300);
    check_eq("t4_br_clear", fifo_clear_o, 1);
    drive(1, 0, 0, 1, 0, 0, 0);
    check_eq("t4_hold_addr", instr_addr_o, 32'h300);
    drive(1, 0, 0, 1, 1, 0, 0);
    check_eq("t4_gnt_addr", instr_addr_o, 32'h300);
    drive(1, 0, 0, 1, 1, 1, 32'h3333_3300);
    check_eq("t4_drop", fifo_valid_o, 0);
    check_eq("t4_new_addr", instr_addr_o, 32'h400);
    drive(0, 0, 0, 1, 0, 1, 32'h4444_4400);
    check_eq("t4_new_val", fifo_valid_o, 1);

    // 5: rvalid in the branch cycle with one other outstanding
    drive(1, 1, 32'h500, 1, 1, 0, 0);
    drive(1, 0, 0, 1, 1, 0, 0);
    check_eq("t5_addr1", instr_addr_o, 32'h504);
    drive(0, 1, 32'h600, 1, 0, 1, 32'h5555_5500);
    check_eq("t5_br_val", fifo_valid_o, 0);
    drive(0, 0, 0, 1, 0, 1, 32'h5555_5504);
    check_eq("t5_drop", fifo_valid_o, 0);
    drive(1, 0, 0, 1, 1, 0, 0);
    check_eq("t5_new_addr", instr_addr_o, 32'h600);
    drive(0, 0, 0, 1, 0, 1, 32'h6666_6600);
    check_eq("t5_new_val", fifo_valid_o, 1);
    check_eq("t5_new_data", fifo_rdata_o, 32'h6666_6600);

    // 6: FIFO full blocks requests; reset inside WAIT_GNT
    drive(1, 0, 0, 0, 0, 0, 0);
    check_eq("t6_nordy_req", instr_req_o, 0);
    check_eq("t6_nordy_busy", busy_o, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    check_eq("t6_addr", instr_addr_o, 32'h604);
    drive(1, 0, 0, 1, 0, 0, 0);
    check_eq("t6_wait_req", instr_req_o, 1);
    rst_ni = 1'b0;
    #1;
    check_eq("t6_rst_req", instr_req_o, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    rst_ni = 1'b1;
    #1;
    check_eq("t6_post_req", instr_req_o, 0);
    check_eq("t6_post_busy", busy_o, 0);
    drive(1, 0, 0, 1, 1, 0, 0);
    check_eq("t6_post_addr", instr_addr_o, 32'h0);
    drive(0, 0, 0, 1, 0, 1, 32'h7777_7700);
    check_eq("t6_post_val", fifo_valid_o, 1);
    drive(0, 0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
